// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line,
// single-word miss fill from memory over an iREN/iwait handshake.
module icache_dm #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FETCH = 1'b1;

  logic              state;
  logic [31:0]       miss_addr;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [31:0]       data_arr [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              fill_done;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign fill_idx  = miss_addr[IDX_W+1:2];
  assign fill_tag  = miss_addr[31:IDX_W+2];

  // Lookup is only honoured in IDLE, so a line being filled is never forwarded.
  assign hit       = imemREN && (state == ST_IDLE) && valid[req_idx] &&
                     (tag_arr[req_idx] == req_tag);
  assign fill_done = (state == ST_FETCH) && !iwait;

  assign ihit      = hit;
  assign imemload  = hit ? data_arr[req_idx] : 32'h0;
  assign iREN      = (state == ST_FETCH);
  assign iaddr     = (state == ST_FETCH) ? miss_addr : 32'h0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      miss_addr <= 32'h0;
      valid     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (imemREN && !hit) begin
            miss_addr <= imemaddr & ~32'h3;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; a reset edge suppresses the fill.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: miss/fill, hits, eviction, redirect,
// dropped request, reset mid-fill and idle quiescence.
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  icache_dm #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives a request that must miss, serves it after `waits` busy cycles,
  // and queues the fill data as the value the following re-lookup must return.
  task automatic serve_miss(input logic [31:0] a, input logic [31:0] d, input int waits);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; #1;
    checks++; if (ihit !== 1'b0) begin failures++; $display("FAIL miss_lookup_ihit addr=%h got=%b want=0", a, ihit); end
    checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL miss_lookup_iren addr=%h got=%b want=0", a, iREN); end
    step();
    for (int i = 0; i <= waits; i++) begin
      iwait = (i < waits); iload = (i < waits) ? $urandom : d; #1;
      checks++; if (iREN !== 1'b1 || iaddr !== a) begin failures++; $display("FAIL fetch_req addr=%h cyc=%0d got iREN=%b iaddr=%h want 1 %h", a, i, iREN, iaddr, a); end
      checks++; if (ihit !== 1'b0) begin failures++; $display("FAIL fetch_ihit addr=%h cyc=%0d got=%b want=0", a, i, ihit); end
      step();
    end
    iwait = 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic expect_hit(input logic [31:0] a);
    logic [31:0] d;
    imemREN = 1'b1; imemaddr = a; #1;
    if (exp_q.size() == 0) begin
      checks++; failures++; $display("FAIL hit_scoreboard_empty addr=%h", a);
    end else begin
      d = exp_q.pop_front();
      checks++; if (ihit !== 1'b1 || imemload !== d) begin failures++; $display("FAIL hit addr=%h got ihit=%b data=%h want 1 %h", a, ihit, imemload, d); end
      checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL hit_iren addr=%h got=%b want=0", a, iREN); end
    end
    step();
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    step(); step();
    nRST = 1'b1; #1;
    checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin failures++; $display("FAIL reset_hit got ihit=%b data=%h want 0 0", ihit, imemload); end
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin failures++; $display("FAIL reset_req got iREN=%b iaddr=%h want 0 0", iREN, iaddr); end
  endtask

  task automatic test_cold_miss();
    serve_miss(32'h0000_0040, 32'h2001_0005, 3);
    expect_hit(32'h0000_0040);
  endtask

  task automatic test_warm_hit();
    serve_miss(32'h0000_0044, 32'h1111_0044, 1);
    expect_hit(32'h0000_0044);
    exp_q.push_back(32'h2001_0005);
    expect_hit(32'h0000_0040);
  endtask

  task automatic test_conflict();
    serve_miss(32'h0000_0080, 32'hAAAA_0080, 0);
    expect_hit(32'h0000_0080);
    serve_miss(32'h0000_0040, 32'h2001_0005, 2);
    expect_hit(32'h0000_0040);
  endtask

  task automatic test_redirect();
    imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1; #1;
    checks++; if (ihit !== 1'b0) begin failures++; $display("FAIL redir_lookup got=%b want=0", ihit); end
    step();
    imemaddr = 32'h0000_0204;
    for (int i = 0; i < 3; i++) begin
      iwait = (i < 2); iload = 32'hCAFE_0100; #1;
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin failures++; $display("FAIL redir_iaddr cyc=%0d got iREN=%b iaddr=%h want 1 00000100", i, iREN, iaddr); end
      checks++; if (ihit !== 1'b0) begin failures++; $display("FAIL redir_ihit cyc=%0d got=%b want=0", i, ihit); end
      step();
    end
    iwait = 1'b1;
    serve_miss(32'h0000_0204, 32'hBEEF_0204, 1);
    expect_hit(32'h0000_0204);
    exp_q.push_back(32'hCAFE_0100);
    expect_hit(32'h0000_0100);
  endtask

  task automatic test_drop();
    imemREN = 1'b1; imemaddr = 32'h0000_0048; iwait = 1'b1; #1;
    step();
    imemREN = 1'b0; iwait = 1'b0; iload = 32'h5555_0048; #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h48) begin failures++; $display("FAIL drop_req got iREN=%b iaddr=%h want 1 00000048", iREN, iaddr); end
    step();
    iwait = 1'b1; #1;
    checks++; if (iREN !== 1'b0 || ihit !== 1'b0) begin failures++; $display("FAIL drop_idle got iREN=%b ihit=%b want 0 0", iREN, ihit); end
    exp_q.push_back(32'h5555_0048);
    expect_hit(32'h0000_0048);
  endtask

  task automatic test_reset_mid_fetch();
    imemREN = 1'b1; imemaddr = 32'h0000_0300; iwait = 1'b1; #1;
    step();
    iwait = 1'b0; iload = 32'hDEAD_BEEF; nRST = 1'b0; #1;
    step();
    nRST = 1'b1; iwait = 1'b1; #1;
    checks++; if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0) begin failures++; $display("FAIL rstfetch_after got iREN=%b ihit=%b data=%h want 0 0 0", iREN, ihit, imemload); end
    serve_miss(32'h0000_0300, 32'h7777_0300, 0);
    expect_hit(32'h0000_0300);
  endtask

  task automatic test_idle_quiet();
    imemREN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imemaddr = (i % 3 == 0) ? 32'h0000_0300 : ($urandom & 32'h0000_0FFC);
      iwait = $urandom_range(0, 1); iload = $urandom; #1;
      checks++; if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0) begin failures++; $display("FAIL idle cyc=%0d addr=%h got iREN=%b ihit=%b data=%h want 0 0 0", i, imemaddr, iREN, ihit, imemload); end
      step();
    end
    iwait = 1'b1;
    exp_q.push_back(32'h7777_0300);
    expect_hit(32'h0000_0300);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_drop();
    test_reset_mid_fetch();
    test_idle_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
